pc_change: RTL and testbench



---
 rtl/pc_change_pkg.sv | 18 +
 rtl/pc_change_npc_calc.sv | 40 ++++
 rtl/pc_change.sv | 51 +++++
 tb/tb_pc_change.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pc_change_pkg.sv
// Shared CPU constants: reset vector and instruction field positions used by
// the next-PC logic.
package pc_change_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    // Jump index field of a J-type instruction.
    localparam int JIDX_LSB = 0;
    localparam int JIDX_MSB = 25;
    localparam int JIDX_W   = JIDX_MSB - JIDX_LSB + 1;

    // Word-aligned jump target: upper nibble of pc4, index, two zero bits.
    function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                                input logic [JIDX_W-1:0] jidx);
        return {pc4[31:28], jidx, 2'b00};
    endfunction

endpackage

// File: rtl/pc_change_npc_calc.sv
// Combinational next-PC selector: sequential, branch, jump and jump-register
// targets resolved by a fixed priority (jr > j/jal > taken beq > pc+4).
module npc_calc
    import pc_change_pkg::*;
(
    input  logic [31:0]       pc_now,
    input  logic [31:0]       o1,
    input  logic [31:0]       o2,
    input  logic [31:0]       imm_s,
    input  logic [JIDX_W-1:0] jidx,
    input  logic              j,
    input  logic              jal,
    input  logic              jr,
    input  logic              branch,
    output logic [31:0]       npc
);

    logic [31:0] pc4;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic        taken;

    // All sums wrap modulo 2^32; the shift drops imm_s[31:30].
    assign pc4    = pc_now + 32'd4;
    assign br_tgt = pc4 + (imm_s << 2);
    assign j_tgt  = jump_target(pc4, jidx);
    assign taken  = branch && (o1 == o2);

    always_comb begin
        npc = pc4;
        if (jr) begin
            npc = o1;
        end else if (j || jal) begin
            npc = j_tgt;
        end else if (taken) begin
            npc = br_tgt;
        end
    end

endmodule

// File: rtl/pc_change.sv
// Program-counter register for the single-cycle CPU; advances every edge to
// the target chosen by npc_calc, or to RESET_PC when clr is sampled high.
module pc_change
    import pc_change_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] o1,
    input  logic [31:0] o2,
    input  logic [31:0] imm_s,
    input  logic        j,
    input  logic        jal,
    input  logic        jr,
    input  logic        branch,
    input  logic [31:0] ins,
    output logic [31:0] pc_now
);

    logic [31:0] pc_q;
    logic [31:0] npc;
    logic        unused_ins_hi;

    // Opcode bits are decoded elsewhere; only the jump index matters here.
    assign unused_ins_hi = ^ins[31:JIDX_MSB+1];

    npc_calc u_npc_calc (
        .pc_now (pc_q),
        .o1     (o1),
        .o2     (o2),
        .imm_s  (imm_s),
        .jidx   (ins[JIDX_MSB:JIDX_LSB]),
        .j      (j),
        .jal    (jal),
        .jr     (jr),
        .branch (branch),
        .npc    (npc)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= npc;
        end
    end

    assign pc_now = pc_q;

endmodule

// File: tb/tb_pc_change.sv
// Self-checking bench for pc_change: directed walk through the key cases,
// then randomized control/operand traffic against a behavioural PC model.
module tb_pc_change;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] o1, o2, imm_s, ins;
    logic        j, jal, jr, branch;
    logic [31:0] pc_now;

    logic [31:0] exp_q[$];
    logic [31:0] model_pc;
    int          n_checks = 0;
    int          n_fail   = 0;

    pc_change #(.RESET_PC(RST_PC)) dut (
        .clk    (clk),
        .clr    (clr),
        .o1     (o1),
        .o2     (o2),
        .imm_s  (imm_s),
        .j      (j),
        .jal    (jal),
        .jr     (jr),
        .branch (branch),
        .ins    (ins),
        .pc_now (pc_now)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "simulation timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", tag, act, exp);
        end
    endtask

    // Behavioural model: next address from the architectural rules.
    function automatic logic [31:0] model_next(input logic [31:0] pc,
                                               input logic c, input logic r,
                                               input logic jj, input logic jl,
                                               input logic br,
                                               input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] imm, input logic [31:0] iw);
        logic [31:0] seq;
        seq = pc + 32'd4;
        if (c)               return RST_PC;
        if (r)               return a;
        if (jj || jl)        return (seq & 32'hF000_0000) | ((iw & 32'h03FF_FFFF) * 32'd4);
        if (br && (a == b))  return seq + imm * 32'd4;
        return seq;
    endfunction

    // Driver: apply one instruction's worth of inputs and check the edge result.
    task automatic step(input string tag, input logic c, input logic r,
                        input logic jj, input logic jl, input logic br,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [31:0] iw);
        @(negedge clk);
        clr = c; jr = r; j = jj; jal = jl; branch = br;
        o1 = a; o2 = b; imm_s = imm; ins = iw;
        exp_q.push_back(model_next(model_pc, c, r, jj, jl, br, a, b, imm, iw));
        #1;
        if (c) check_eq({tag, "_hold"}, pc_now, model_pc);
        @(posedge clk);
        #1;
        model_pc = exp_q.pop_front();
        check_eq(tag, pc_now, model_pc);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    initial begin
        clr = 1'b1; jr = 1'b0; j = 1'b0; jal = 1'b0; branch = 1'b0;
        o1 = '0; o2 = '0; imm_s = '0; ins = '0;
        @(posedge clk);
        #1;
        model_pc = RST_PC;
        check_eq("reset", pc_now, 32'h0000_3000);

        // Sequencing and mid-run clear
        idle("seq1");            check_eq("seq1_abs", pc_now, 32'h0000_3004);
        idle("seq2");            check_eq("seq2_abs", pc_now, 32'h0000_3008);
        step("clr_mid", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        check_eq("clr_mid_abs", pc_now, 32'h0000_3000);
        idle("after_clr");       check_eq("after_clr_abs", pc_now, 32'h0000_3004);
        idle("seq3");            check_eq("seq3_abs", pc_now, 32'h0000_3008);

        // Branches
        step("beq_back", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd5, 32'd5, 32'hFFFF_FFFE, 0);
        check_eq("beq_back_abs", pc_now, 32'h0000_3004);
        idle("seq4");
        step("beq_ne", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd5, 32'd6, 32'hFFFF_FFFE, 0);
        check_eq("beq_ne_abs", pc_now, 32'h0000_300C);
        step("jr_3008", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3008, 0, 0, 0);
        step("beq_fwd", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd7, 32'd7, 32'd3, 0);
        check_eq("beq_fwd_abs", pc_now, 32'h0000_3018);

        // Jumps
        step("clr2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        step("j", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 32'h0800_0C10);
        check_eq("j_abs", pc_now, 32'h0000_3040);
        step("clr3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        step("jal", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 32'h0C00_0C10);
        check_eq("jal_abs", pc_now, 32'h0000_3040);

        // Jump register and priority
        step("jr", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_4000, 0, 0, 0);
        check_eq("jr_abs", pc_now, 32'h0000_4000);
        step("jr_prio", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_4000, 32'h0000_4000, 32'd8, 32'h0800_0C10);
        check_eq("jr_prio_abs", pc_now, 32'h0000_4000);
        step("j_over_beq", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd1, 32'd1, 32'd8, 32'h0800_0100);
        check_eq("j_over_beq_abs", pc_now, 32'h0000_0400);
        step("clr_prio", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_4000, 32'h0000_4000, 0, 0);
        check_eq("clr_prio_abs", pc_now, 32'h0000_3000);

        // Wrap and unaligned jr
        step("jr_top", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 0, 0, 0);
        idle("wrap");            check_eq("wrap_abs", pc_now, 32'h0000_0000);
        step("jr_odd", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1234_5677, 0, 0, 0);
        check_eq("jr_odd_abs", pc_now, 32'h1234_5677);
        step("j_upper", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 32'hFFFF_FFFF);
        check_eq("j_upper_abs", pc_now, 32'h1FFF_FFFC);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic        rc, rr, rj, rl, rb;
            logic [31:0] ra, rbv, ri, rw;
            rc  = ($urandom_range(0, 39) == 0);
            rr  = ($urandom_range(0, 7) == 0);
            rj  = ($urandom_range(0, 7) == 0);
            rl  = ($urandom_range(0, 9) == 0);
            rb  = ($urandom_range(0, 2) == 0);
            ra  = $urandom;
            rbv = ($urandom_range(0, 1) == 0) ? ra : 32'($urandom);
            ri  = ($urandom_range(0, 1) == 0) ? 32'($signed(16'($urandom))) : 32'($urandom);
            rw  = $urandom;
            step("rand", rc, rr, rj, rl, rb, ra, rbv, ri, rw);
        end

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL exp_q_drain: actual=%0d required=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
